// File: rtl/atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// atm_session_ctrl
//   ATM session controller. Holds a small account table (number, PIN, balance,
//   lock state, wrong-PIN count), authenticates a card by scanning every slot
//   (fixed latency, independent of where or whether the account matches), then
//   serves balance / withdraw / deposit / transfer / logout requests until the
//   user logs out, aborts with exit, or the menu idles too long.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   exit              abort the current session (ignored in IDLE)
//   prov_we/idx/acc/pin
//                     provision one table slot (IDLE only), balance := INIT_BALANCE
//   card_valid, accNumber, pin
//                     login request, accepted when ready in IDLE
//   op_valid, menuOption, amount, destinationAcc
//                     menu request, accepted when ready in MENU
//   ready             request may be accepted this cycle (IDLE or MENU)
//   done              one-cycle result pulse; error/err_code qualified by it
//   error, err_code   0 ok,1 bad creds,2 locked,3 insufficient,4 bad dest,
//                     5 overflow,6 bad op,7 timeout
//   balance           last reported balance, held between results
//   logged_in         high while a session is open (MENU/EXEC/DEST)
// -----------------------------------------------------------------------------
module atm_session_ctrl #(
   parameter int NUM_ACCOUNTS = 10,
   parameter int ACC_W        = 12,
   parameter int PIN_W        = 4,
   parameter int BAL_W        = 16,
   parameter int AMT_W        = 11,
   parameter int MAX_TRIES    = 3,
   parameter int TIMEOUT_CYC  = 255,
   parameter int INIT_BALANCE = 500,
   localparam int IDX_W       = $clog2(NUM_ACCOUNTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exit,
   input  logic             prov_we,
   input  logic [IDX_W-1:0] prov_idx,
   input  logic [ACC_W-1:0] prov_acc,
   input  logic [PIN_W-1:0] prov_pin,
   input  logic             card_valid,
   input  logic [ACC_W-1:0] accNumber,
   input  logic [PIN_W-1:0] pin,
   input  logic             op_valid,
   input  logic [2:0]       menuOption,
   input  logic [AMT_W-1:0] amount,
   input  logic [ACC_W-1:0] destinationAcc,
   output logic             ready,
   output logic             done,
   output logic             error,
   output logic [2:0]       err_code,
   output logic [BAL_W-1:0] balance,
   output logic             logged_in
);

   localparam int SCAN_W = $clog2(NUM_ACCOUNTS + 1);
   localparam int TRY_W  = $clog2(MAX_TRIES + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SCAN, S_MENU, S_EXEC, S_DEST
   } state_e;

   typedef enum logic [2:0] {
      ERR_OK, ERR_CREDS, ERR_LOCKED, ERR_FUNDS,
      ERR_DEST, ERR_OVFL, ERR_OP, ERR_TIMEOUT
   } err_e;

   localparam logic [2:0] OP_BAL    = 3'd0;
   localparam logic [2:0] OP_WDRAW  = 3'd1;
   localparam logic [2:0] OP_DEP    = 3'd2;
   localparam logic [2:0] OP_XFER   = 3'd3;
   localparam logic [2:0] OP_LOGOUT = 3'd4;

   // Account table
   logic [ACC_W-1:0] acc_q   [NUM_ACCOUNTS];
   logic [PIN_W-1:0] pin_q   [NUM_ACCOUNTS];
   logic [BAL_W-1:0] bal_q   [NUM_ACCOUNTS];
   logic             valid_q [NUM_ACCOUNTS];
   logic             lock_q  [NUM_ACCOUNTS];
   logic [TRY_W-1:0] tries_q [NUM_ACCOUNTS];

   // Control state
   state_e            state_q,   state_d;
   logic [SCAN_W-1:0] scan_q,    scan_d;
   logic              found_q,   found_d;
   logic [IDX_W-1:0]  match_q,   match_d;
   logic [IDX_W-1:0]  cur_q,     cur_d;
   logic [ACC_W-1:0]  req_acc_q, req_acc_d;   // card number in SCAN, destination in DEST
   logic [PIN_W-1:0]  req_pin_q, req_pin_d;
   logic [2:0]        op_q,      op_d;
   logic [AMT_W-1:0]  amt_q,     amt_d;
   logic              exec_ph_q, exec_ph_d;
   logic [IDLE_W-1:0] idle_q,    idle_d;

   // Output registers
   logic              done_q,    done_d;
   err_e              code_q,    code_d;
   logic [BAL_W-1:0]  bal_o_q,   bal_o_d;
   logic              error_q, ready_q, logged_q;

   // Table update requests from the FSM
   logic              prov_en;
   logic              tries_we, lock_set;
   logic [TRY_W-1:0]  tries_val;
   logic              src_we, dst_we;
   logic [BAL_W-1:0]  src_val, dst_val;

   // Datapath helpers
   logic [IDX_W-1:0]  scan_i;
   logic              scan_end, scan_hit;
   logic [BAL_W-1:0]  amt_ext, src_bal, dst_bal;
   logic [BAL_W:0]    dep_sum, xfer_sum;
   logic [TRY_W-1:0]  tries_nxt;

   assign prov_en   = (state_q == S_IDLE) && prov_we && (int'(prov_idx) < NUM_ACCOUNTS);

   assign scan_i    = scan_q[IDX_W-1:0];
   assign scan_end  = (scan_q == SCAN_W'(NUM_ACCOUNTS));
   // First match only, so duplicate account numbers resolve to the lowest slot.
   assign scan_hit  = !found_q && valid_q[scan_i] && (acc_q[scan_i] == req_acc_q);

   assign amt_ext   = BAL_W'(amt_q);
   assign src_bal   = bal_q[cur_q];
   assign dst_bal   = bal_q[match_q];
   // One extra bit so an overflowing sum is visible rather than wrapping.
   assign dep_sum   = {1'b0, src_bal} + {1'b0, amt_ext};
   assign xfer_sum  = {1'b0, dst_bal} + {1'b0, amt_ext};
   assign tries_nxt = tries_q[match_q] + TRY_W'(1);

   // NOTE: every output of this block gets a default before the case statement,
   // so no path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      scan_d    = scan_q;
      found_d   = found_q;
      match_d   = match_q;
      cur_d     = cur_q;
      req_acc_d = req_acc_q;
      req_pin_d = req_pin_q;
      op_d      = op_q;
      amt_d     = amt_q;
      exec_ph_d = exec_ph_q;
      idle_d    = idle_q;
      done_d    = 1'b0;
      code_d    = code_q;
      bal_o_d   = bal_o_q;
      tries_we  = 1'b0;
      tries_val = '0;
      lock_set  = 1'b0;
      src_we    = 1'b0;
      src_val   = '0;
      dst_we    = 1'b0;
      dst_val   = '0;

      case (state_q)
         S_IDLE: begin
            if (card_valid && ready_q) begin
               req_acc_d = accNumber;
               req_pin_d = pin;
               scan_d    = '0;
               found_d   = 1'b0;
               match_d   = '0;
               state_d   = S_SCAN;
            end
         end

         S_SCAN: begin
            if (!scan_end) begin
               if (scan_hit) begin
                  found_d = 1'b1;
                  match_d = scan_i;
               end
               scan_d = scan_q + SCAN_W'(1);
            end else begin
               done_d  = 1'b1;
               state_d = S_IDLE;
               bal_o_d = '0;
               if (!found_q) begin
                  code_d = ERR_CREDS;
               end else if (lock_q[match_q]) begin
                  code_d = ERR_LOCKED;
               end else if (pin_q[match_q] != req_pin_q) begin
                  code_d    = ERR_CREDS;
                  tries_we  = 1'b1;
                  tries_val = tries_nxt;
                  lock_set  = (tries_nxt == TRY_W'(MAX_TRIES));
               end else begin
                  code_d    = ERR_OK;
                  tries_we  = 1'b1;
                  tries_val = '0;
                  cur_d     = match_q;
                  bal_o_d   = bal_q[match_q];
                  idle_d    = '0;
                  state_d   = S_MENU;
               end
            end
         end

         S_MENU: begin
            // Timeout outranks a request arriving on the same edge.
            if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
               done_d  = 1'b1;
               code_d  = ERR_TIMEOUT;
               bal_o_d = '0;
               state_d = S_IDLE;
            end else if (op_valid && ready_q) begin
               op_d      = menuOption;
               amt_d     = amount;
               req_acc_d = destinationAcc;
               exec_ph_d = 1'b0;
               idle_d    = '0;
               state_d   = S_EXEC;
            end else begin
               idle_d = idle_q + IDLE_W'(1);
            end
         end

         S_EXEC: begin
            if (!exec_ph_q) begin
               // First EXEC cycle: transfers branch off to the destination scan,
               // everything else resolves on the following edge.
               if (op_q == OP_XFER) begin
                  scan_d  = '0;
                  found_d = 1'b0;
                  match_d = '0;
                  state_d = S_DEST;
               end else begin
                  exec_ph_d = 1'b1;
               end
            end else begin
               done_d  = 1'b1;
               idle_d  = '0;
               state_d = S_MENU;
               bal_o_d = src_bal;
               case (op_q)
                  OP_BAL:   code_d = ERR_OK;
                  OP_WDRAW: begin
                     if (amt_ext <= src_bal) begin
                        code_d  = ERR_OK;
                        src_we  = 1'b1;
                        src_val = src_bal - amt_ext;
                        bal_o_d = src_bal - amt_ext;
                     end else begin
                        code_d  = ERR_FUNDS;
                     end
                  end
                  OP_DEP: begin
                     if (!dep_sum[BAL_W]) begin
                        code_d  = ERR_OK;
                        src_we  = 1'b1;
                        src_val = dep_sum[BAL_W-1:0];
                        bal_o_d = dep_sum[BAL_W-1:0];
                     end else begin
                        code_d  = ERR_OVFL;
                     end
                  end
                  OP_LOGOUT: begin
                     code_d  = ERR_OK;
                     bal_o_d = '0;
                     state_d = S_IDLE;
                  end
                  default:  code_d = ERR_OP;
               endcase
            end
         end

         S_DEST: begin
            if (!scan_end) begin
               if (scan_hit) begin
                  found_d = 1'b1;
                  match_d = scan_i;
               end
               scan_d = scan_q + SCAN_W'(1);
            end else begin
               done_d  = 1'b1;
               idle_d  = '0;
               state_d = S_MENU;
               bal_o_d = src_bal;
               if (!found_q || (match_q == cur_q)) begin
                  code_d = ERR_DEST;
               end else if (amt_ext > src_bal) begin
                  code_d = ERR_FUNDS;
               end else if (xfer_sum[BAL_W]) begin
                  code_d = ERR_OVFL;
               end else begin
                  code_d  = ERR_OK;
                  src_we  = 1'b1;
                  src_val = src_bal - amt_ext;
                  dst_we  = 1'b1;
                  dst_val = xfer_sum[BAL_W-1:0];
                  bal_o_d = src_bal - amt_ext;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Abort drops everything in flight: no result, no table update.
      if (exit && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         done_d   = 1'b0;
         bal_o_d  = '0;
         tries_we = 1'b0;
         lock_set = 1'b0;
         src_we   = 1'b0;
         dst_we   = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         scan_q    <= '0;
         found_q   <= 1'b0;
         match_q   <= '0;
         cur_q     <= '0;
         req_acc_q <= '0;
         req_pin_q <= '0;
         op_q      <= '0;
         amt_q     <= '0;
         exec_ph_q <= 1'b0;
         idle_q    <= '0;
         done_q    <= 1'b0;
         code_q    <= ERR_OK;
         bal_o_q   <= '0;
         error_q   <= 1'b0;
         ready_q   <= 1'b0;
         logged_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         scan_q    <= scan_d;
         found_q   <= found_d;
         match_q   <= match_d;
         cur_q     <= cur_d;
         req_acc_q <= req_acc_d;
         req_pin_q <= req_pin_d;
         op_q      <= op_d;
         amt_q     <= amt_d;
         exec_ph_q <= exec_ph_d;
         idle_q    <= idle_d;
         done_q    <= done_d;
         code_q    <= code_d;
         bal_o_q   <= bal_o_d;
         error_q   <= (code_d != ERR_OK);
         ready_q   <= (state_d == S_IDLE) || (state_d == S_MENU);
         logged_q  <= (state_d == S_MENU) || (state_d == S_EXEC) || (state_d == S_DEST);
      end
   end

   // NOTE: the table payload (number, PIN, balance) is not reset; it is only
   // ever read through a slot whose valid bit is set, and valid bits are reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (prov_en) begin
            acc_q[prov_idx] <= prov_acc;
            pin_q[prov_idx] <= prov_pin;
            bal_q[prov_idx] <= BAL_W'(INIT_BALANCE);
         end
         if (src_we) bal_q[cur_q]   <= src_val;
         if (dst_we) bal_q[match_q] <= dst_val;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            valid_q[i] <= 1'b0;
            lock_q[i]  <= 1'b0;
            tries_q[i] <= '0;
         end
      end else begin
         if (prov_en) begin
            valid_q[prov_idx] <= 1'b1;
            lock_q[prov_idx]  <= 1'b0;
            tries_q[prov_idx] <= '0;
         end
         if (tries_we) begin
            tries_q[match_q] <= tries_val;
            if (lock_set) lock_q[match_q] <= 1'b1;
         end
      end
   end

   assign ready     = ready_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_code  = code_q;
   assign balance   = bal_o_q;
   assign logged_in = logged_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// -----------------------------------------------------------------------------
// tb_atm_session_ctrl
//   Directed bench for atm_session_ctrl with default parameters. Inputs change
//   1 ns after a rising edge; outputs are sampled at the same point, i.e. they
//   reflect the edge just taken. Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_atm_session_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        exit = 1'b0;
   logic        prov_we = 1'b0;
   logic [3:0]  prov_idx = '0;
   logic [11:0] prov_acc = '0;
   logic [3:0]  prov_pin = '0;
   logic        card_valid = 1'b0;
   logic [11:0] accNumber = '0;
   logic [3:0]  pin = '0;
   logic        op_valid = 1'b0;
   logic [2:0]  menuOption = '0;
   logic [10:0] amount = '0;
   logic [11:0] destinationAcc = '0;
   logic        ready, done, error, logged_in;
   logic [2:0]  err_code;
   logic [15:0] balance;

   int tests = 0;
   int fails = 0;

   atm_session_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .exit           (exit),
      .prov_we        (prov_we),
      .prov_idx       (prov_idx),
      .prov_acc       (prov_acc),
      .prov_pin       (prov_pin),
      .card_valid     (card_valid),
      .accNumber      (accNumber),
      .pin            (pin),
      .op_valid       (op_valid),
      .menuOption     (menuOption),
      .amount         (amount),
      .destinationAcc (destinationAcc),
      .ready          (ready),
      .done           (done),
      .error          (error),
      .err_code       (err_code),
      .balance        (balance),
      .logged_in      (logged_in)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic provision(input logic [3:0] idx, input logic [11:0] a, input logic [3:0] p);
      prov_we  = 1'b1;
      prov_idx = idx;
      prov_acc = a;
      prov_pin = p;
      step(1);
      prov_we  = 1'b0;
   endtask

   // Login: accepted at edge E, result exactly at E+11.
   task automatic login(input string tag, input logic [11:0] a, input logic [3:0] p,
                        input logic [2:0] code);
      card_valid = 1'b1;
      accNumber  = a;
      pin        = p;
      step(1);
      card_valid = 1'b0;
      step(10);
      check({tag, "_early"}, done, 0);
      step(1);
      check({tag, "_done"}, done, 1);
      check({tag, "_code"}, err_code, code);
      check({tag, "_err"}, error, (code != 0));
      check({tag, "_li"}, logged_in, (code == 0));
   endtask

   // Menu op: accepted at edge E, result at E+lat.
   task automatic do_op(input string tag, input logic [2:0] opt, input logic [10:0] amt,
                        input logic [11:0] dst, input int lat, input logic [2:0] code,
                        input logic [15:0] bal);
      op_valid       = 1'b1;
      menuOption     = opt;
      amount         = amt;
      destinationAcc = dst;
      step(1);
      op_valid = 1'b0;
      step(lat - 1);
      check({tag, "_early"}, done, 0);
      step(1);
      check({tag, "_done"}, done, 1);
      check({tag, "_code"}, err_code, code);
      check({tag, "_bal"}, balance, bal);
   endtask

   initial begin
      // Reset state
      step(2);
      check("rst_done", done, 0);
      check("rst_ready", ready, 0);
      check("rst_li", logged_in, 0);
      check("rst_bal", balance, 0);
      check("rst_code", err_code, 0);
      check("rst_err", error, 0);
      rst = 1'b0;
      step(1);
      check("idle_ready", ready, 1);

      provision(4'd0, 12'd2749, 4'd0);
      provision(4'd1, 12'd2175, 4'd9);
      provision(4'd2, 12'd100, 4'd7);
      provision(4'd3, 12'd2749, 4'd3);   // duplicate number, higher slot

      // Duplicate resolves to slot 0, whose PIN is 0
      login("dup", 12'd2749, 4'd3, 3'd1);
      login("login0", 12'd2749, 4'd0, 3'd0);
      check("login0_bal", balance, 500);
      check("login0_ready", ready, 1);
      step(1);
      check("done_pulse", done, 0);

      do_op("wd600", 3'd1, 11'd600, 12'd0, 2, 3'd3, 16'd500);
      do_op("wd200", 3'd1, 11'd200, 12'd0, 2, 3'd0, 16'd300);
      do_op("dep200", 3'd2, 11'd200, 12'd0, 2, 3'd0, 16'd500);
      do_op("xf_unk", 3'd3, 11'd100, 12'd1234, 12, 3'd4, 16'd500);
      do_op("xf_self", 3'd3, 11'd100, 12'd2749, 12, 3'd4, 16'd500);
      do_op("xf_ok", 3'd3, 11'd100, 12'd2175, 12, 3'd0, 16'd400);
      do_op("xf_funds", 3'd3, 11'd401, 12'd2175, 12, 3'd3, 16'd400);
      do_op("badop", 3'd6, 11'd5, 12'd0, 2, 3'd6, 16'd400);
      do_op("bal", 3'd0, 11'd0, 12'd0, 2, 3'd0, 16'd400);
      do_op("wd_all", 3'd1, 11'd400, 12'd0, 2, 3'd0, 16'd0);
      do_op("dep400", 3'd2, 11'd400, 12'd0, 2, 3'd0, 16'd400);
      do_op("logout0", 3'd4, 11'd0, 12'd0, 2, 3'd0, 16'd0);
      check("logout0_li", logged_in, 0);

      // Requests outside ready are dropped
      op_valid = 1'b1;
      step(1);
      op_valid = 1'b0;
      step(2);
      check("idle_op_ign", done, 0);

      // Deposit boundary on slot 2: 500 + 31*2047 = 63957, +43 = 64000
      login("login2", 12'd100, 4'd7, 3'd0);
      for (int i = 0; i < 31; i++) begin
         do_op("dep_loop", 3'd2, 11'd2047, 12'd0, 2, 3'd0, 16'(500 + 2047 * (i + 1)));
      end
      do_op("dep43", 3'd2, 11'd43, 12'd0, 2, 3'd0, 16'd64000);
      do_op("dep_ovf", 3'd2, 11'd2047, 12'd0, 2, 3'd5, 16'd64000);
      do_op("dep_max", 3'd2, 11'd1535, 12'd0, 2, 3'd0, 16'd65535);
      do_op("dep_ovf1", 3'd2, 11'd1, 12'd0, 2, 3'd5, 16'd65535);
      do_op("logout2", 3'd4, 11'd0, 12'd0, 2, 3'd0, 16'd0);

      // Slot 1 received 100 earlier; destination overflow into slot 2
      login("login1", 12'd2175, 4'd9, 3'd0);
      check("login1_bal", balance, 600);
      do_op("xf_dovf", 3'd3, 11'd1, 12'd100, 12, 3'd5, 16'd600);

      // Exit during the destination scan: no result, no commit
      op_valid       = 1'b1;
      menuOption     = 3'd3;
      amount         = 11'd50;
      destinationAcc = 12'd2749;
      step(1);
      op_valid = 1'b0;
      step(3);
      exit = 1'b1;
      step(1);
      exit = 1'b0;
      check("exit_done", done, 0);
      check("exit_li", logged_in, 0);
      check("exit_bal", balance, 0);
      check("exit_ready", ready, 1);
      step(10);
      check("exit_no_late", done, 0);

      // Exit in IDLE changes nothing
      exit = 1'b1;
      step(1);
      exit = 1'b0;
      check("exit_idle_rdy", ready, 1);

      login("relogin1", 12'd2175, 4'd9, 3'd0);
      check("relogin1_bal", balance, 600);

      // Idle timeout fires on the 255th idle MENU edge
      step(254);
      check("to_early", done, 0);
      check("to_early_li", logged_in, 1);
      step(1);
      check("to_done", done, 1);
      check("to_code", err_code, 7);
      check("to_err", error, 1);
      check("to_li", logged_in, 0);
      check("to_bal", balance, 0);

      // Lockout after three wrong PINs
      login("bad1", 12'd2749, 4'd5, 3'd1);
      login("bad2", 12'd2749, 4'd5, 3'd1);
      login("bad3", 12'd2749, 4'd5, 3'd1);
      login("locked", 12'd2749, 4'd0, 3'd2);
      provision(4'd0, 12'd2749, 4'd0);
      login("reprov", 12'd2749, 4'd0, 3'd0);
      check("reprov_bal", balance, 500);
      do_op("logout3", 3'd4, 11'd0, 12'd0, 2, 3'd0, 16'd0);

      // Reset in the middle of a scan
      card_valid = 1'b1;
      accNumber  = 12'd2749;
      pin        = 4'd0;
      step(1);
      card_valid = 1'b0;
      step(4);
      rst = 1'b1;
      step(1);
      check("mrst_done", done, 0);
      check("mrst_ready", ready, 0);
      check("mrst_li", logged_in, 0);
      check("mrst_bal", balance, 0);
      check("mrst_code", err_code, 0);
      rst = 1'b0;
      step(1);
      login("post_rst", 12'd2749, 4'd0, 3'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
